scanline_ctrl: RTL and testbench
================================

SCANLINE_CTRL -- requirements
Module: scanline_ctrl

Interface
REQ-001 Parameter LINE_W, default 10: width of all line counters and line-count outputs.
REQ-002 Parameter MIN_LINES, default 16: smallest frame line count accepted for lock.
REQ-003 iPCLK  in  1  pixel clock; sole clock, all state on rising edge.
REQ-004 iRST  in  1  reset; synchronous, active-high.
REQ-005 iSCANLINES  in  2  requested dim level (00 none / 01 25% / 10 50% / 11 75%).
REQ-006 iV2  in  1  phase mode: 0 = classic alternate, 1 = cycling.
REQ-007 iFIELD_ALT  in  1  1 = invert classic phase on odd frames.
REQ-008 iHS  in  1  core hsync, active-high.
REQ-009 iVS  in  1  core vsync, active-high.
REQ-010 iDE  in  1  core data enable.
REQ-011 iCE  in  1  core pixel clock enable.
REQ-012 oLEVEL  out  2  per-line scanline select driven to the dimming datapath.
REQ-013 oLOCKED  out  1  frame timing stable.
REQ-014 oLINES  out  LINE_W  total lines of last completed frame.
REQ-015 oACTIVE  out  LINE_W  lines of last completed frame containing >=1 pixel with iDE&iCE.
REQ-016 oFIELD  out  1  frame parity, toggles every frame start.

Function
REQ-017 HS edge = iHS low in current cycle and high in previous cycle; VS edge likewise on iVS; both detected from one registered copy each.
REQ-018 Frame start = VS edge; line start = HS edge.
REQ-019 At frame start, the shall latch iSCANLINES, iV2, iFIELD_ALT into cfg registers; cfg is constant for the rest of the frame.
REQ-020 Line counter: increments on each HS edge; saturates at 2^LINE_W-1 with a sticky overflow flag; cleared at frame start.
REQ-021 Active counter: per-line flag set by any cycle with iDE&iCE; counter increments by the flag at each HS edge and clears the flag; cleared at frame start.
REQ-022 At frame start, oLINES/oACTIVE load the pre-clear counter values (active count includes the still-open flag); oFIELD toggles.
REQ-023 Simultaneous HS and VS edge in one cycle: processed as frame start only; no line increment.
REQ-024 FSM states SEARCH, MEASURE, LOCKED; reset state SEARCH.
REQ-025 SEARCH -> MEASURE at first frame start; captured count is discarded (partial frame).
REQ-026 MEASURE: at frame start, store line count as reference; -> LOCKED if count equals previous reference, count >= MIN_LINES and no overflow; else stay MEASURE.
REQ-027 LOCKED: at frame start, count differing from reference, count < MIN_LINES, or overflow -> SEARCH; else stay.
REQ-028 oLOCKED = 1 exactly while state is LOCKED (registered, same cycle as state).
REQ-029 Phase counter (2 bits): set at frame start to 0, or to cfg level if cfg FIELD_ALT=1, iV2=0 and new oFIELD=1.
REQ-030 Classic mode at HS edge: phase <= phase XOR cfg level.
REQ-031 V2 mode at HS edge: phase <= 0 if phase == cfg level, else phase + 1.
REQ-032 cfg level 00: phase held 0 in both modes.
REQ-033 oLEVEL = phase when LOCKED, else 00 (bypass); registered, updates on the clock edge ending the cycle in which the HS/VS edge is detected.
REQ-034 Leaving LOCKED forces oLEVEL 00 at the same edge as the state change.
REQ-035 iSCANLINES changes mid-frame have no effect until next frame start.

Reset
REQ-036 iRST=1 at a clock edge: state SEARCH, all counters, phase, cfg, edge-detect registers, oFIELD, oLINES, oACTIVE, oLEVEL, oLOCKED <= 0.
REQ-037 iRST has priority over every edge event in the same cycle.
REQ-038 Reset mid-frame: no spurious HS/VS edge produced in the first cycle after release, even if iHS/iVS are low.

Verification
REQ-039 Reset then 3 frames of 262 lines, 240 active, iSCANLINES=10, iV2=0 -> oLOCKED=1 after 3rd frame start; oLINES=262, oACTIVE=240; oLEVEL alternates 00,10,00,10 per line.
REQ-040 Locked, iV2=1, iSCANLINES=11 latched -> oLEVEL sequence 00,01,10,11,00 across successive lines; change iSCANLINES to 01 mid-frame -> sequence unchanged until next VS edge.
REQ-041 Locked 262-line stream, then one 263-line frame -> at its frame start oLOCKED=0, oLEVEL=00; lock reacquired after two further equal frames.
REQ-042 HS and VS falling in same cycle -> line counter 0, phase reset, oLINES equals lines before the event (no +1).
REQ-043 Frame of 1100 lines with LINE_W=10 -> oLINES=1023, state SEARCH; frame of 8 lines twice -> never LOCKED (MIN_LINES=16).
REQ-044 iFIELD_ALT=1, iSCANLINES=01, classic -> first line of even frames 00, of odd frames 01; iRST asserted mid-line -> all outputs 0 next cycle, no edge on release.

Source files
------------

// File: rtl/scanline_ctrl.sv
// Scanline phase controller: tracks frame timing from core syncs, locks on stable
// line counts and drives the per-line dim level for the scanline datapath.
module scanline_ctrl #(
  parameter int LINE_W    = 10,
  parameter int MIN_LINES = 16
) (
  input  logic              iPCLK,
  input  logic              iRST,
  input  logic [1:0]        iSCANLINES,
  input  logic              iV2,
  input  logic              iFIELD_ALT,
  input  logic              iHS,
  input  logic              iVS,
  input  logic              iDE,
  input  logic              iCE,
  output logic [1:0]        oLEVEL,
  output logic              oLOCKED,
  output logic [LINE_W-1:0] oLINES,
  output logic [LINE_W-1:0] oACTIVE,
  output logic              oFIELD
);

  localparam logic [1:0] SEARCH  = 2'd0;
  localparam logic [1:0] MEASURE = 2'd1;
  localparam logic [1:0] LOCKED  = 2'd2;

  localparam logic [LINE_W-1:0] CNT_MAX = {LINE_W{1'b1}};
  localparam logic [LINE_W-1:0] CNT_ONE = {{(LINE_W-1){1'b0}}, 1'b1};
  localparam logic [LINE_W-1:0] CNT_MIN = LINE_W'(MIN_LINES);

  typedef struct packed {
    logic [1:0] level;
    logic       v2;
    logic       field_alt;
  } cfg_t;

  logic              hs_q, vs_q;
  logic              hs_edge, vs_edge;
  logic              de_ce, act_now;
  cfg_t              cfg_q, cfg_d;
  logic [1:0]        state, state_nxt;
  logic [1:0]        phase, phase_nxt;
  logic [LINE_W-1:0] line_cnt, act_cnt, ref_cnt, act_total;
  logic              line_ovf, act_flag, lines_ok;

  // Falling edges only; a simultaneous HS+VS edge is treated purely as frame start.
  assign hs_edge = hs_q & ~iHS;
  assign vs_edge = vs_q & ~iVS;
  assign de_ce   = iDE & iCE;
  assign act_now = act_flag | de_ce;

  assign act_total = (act_now && act_cnt != CNT_MAX) ? act_cnt + CNT_ONE : act_cnt;
  assign lines_ok  = !line_ovf && (line_cnt >= CNT_MIN);

  // The cfg seen at a frame-start edge is the freshly latched one.
  assign cfg_d = vs_edge ? cfg_t'{iSCANLINES, iV2, iFIELD_ALT} : cfg_q;

  always_comb begin
    state_nxt = state;
    if (vs_edge) begin
      case (state)
        SEARCH:  state_nxt = MEASURE;
        MEASURE: if (line_cnt == ref_cnt && lines_ok) state_nxt = LOCKED;
        LOCKED:  if (line_cnt != ref_cnt || !lines_ok) state_nxt = SEARCH;
        default: state_nxt = SEARCH;
      endcase
    end
  end

  always_comb begin
    phase_nxt = phase;
    if (vs_edge) begin
      phase_nxt = (cfg_d.field_alt && !cfg_d.v2 && !oFIELD) ? cfg_d.level : 2'd0;
    end else if (hs_edge) begin
      if (cfg_d.level == 2'd0)
        phase_nxt = 2'd0;
      else if (!cfg_d.v2)
        phase_nxt = phase ^ cfg_d.level;
      else
        phase_nxt = (phase == cfg_d.level) ? 2'd0 : phase + 2'd1;
    end
  end

  always_ff @(posedge iPCLK) begin
    if (iRST) begin
      hs_q     <= 1'b0;
      vs_q     <= 1'b0;
      cfg_q    <= '0;
      state    <= SEARCH;
      phase    <= 2'd0;
      line_cnt <= '0;
      line_ovf <= 1'b0;
      act_cnt  <= '0;
      act_flag <= 1'b0;
      ref_cnt  <= '0;
      oLEVEL   <= 2'd0;
      oLOCKED  <= 1'b0;
      oLINES   <= '0;
      oACTIVE  <= '0;
      oFIELD   <= 1'b0;
    end else begin
      hs_q    <= iHS;
      vs_q    <= iVS;
      cfg_q   <= cfg_d;
      state   <= state_nxt;
      phase   <= phase_nxt;
      oLOCKED <= (state_nxt == LOCKED);
      if (hs_edge || vs_edge)
        oLEVEL <= (state_nxt == LOCKED) ? phase_nxt : 2'd0;

      if (vs_edge) begin
        oLINES   <= line_cnt;
        oACTIVE  <= act_total;
        oFIELD   <= ~oFIELD;
        line_cnt <= '0;
        line_ovf <= 1'b0;
        act_cnt  <= '0;
        act_flag <= 1'b0;
        if (state == MEASURE)
          ref_cnt <= line_cnt;
      end else if (hs_edge) begin
        if (line_cnt == CNT_MAX)
          line_ovf <= 1'b1;
        else
          line_cnt <= line_cnt + CNT_ONE;
        if (act_flag && act_cnt != CNT_MAX)
          act_cnt <= act_cnt + CNT_ONE;
        act_flag <= de_ce;
      end else if (de_ce) begin
        act_flag <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_scanline_ctrl.sv
// Bench for scanline_ctrl: frame table plus hand sequences, per-line level scoreboard.
module tb_scanline_ctrl;

  logic       iPCLK = 1'b0;
  logic       iRST, iV2, iFIELD_ALT, iHS, iVS, iDE, iCE;
  logic [1:0] iSCANLINES;
  logic [1:0] oLEVEL;
  logic       oLOCKED, oFIELD;
  logic [9:0] oLINES, oACTIVE;

  scanline_ctrl #(.LINE_W(10), .MIN_LINES(16)) dut (
    .iPCLK(iPCLK), .iRST(iRST), .iSCANLINES(iSCANLINES), .iV2(iV2),
    .iFIELD_ALT(iFIELD_ALT), .iHS(iHS), .iVS(iVS), .iDE(iDE), .iCE(iCE),
    .oLEVEL(oLEVEL), .oLOCKED(oLOCKED), .oLINES(oLINES), .oACTIVE(oACTIVE),
    .oFIELD(oFIELD)
  );

  always #5 iPCLK = ~iPCLK;

  int tests = 0;
  int fails = 0;

  // chk_mode: -1 no per-line check, 0 expect bypass 00, 1 classic, 2 cycling
  int         chk_mode = -1;
  logic [1:0] chk_lvl  = 2'd0;
  logic [1:0] exp_ph   = 2'd0;
  logic [1:0] sb[$];

  typedef struct {
    logic [1:0] scan;
    logic       v2;
    logic       falt;
    int         n_lines;
    int         n_act;
    int         chg_line;
    logic [1:0] chg_val;
    int         mode;
    logic       exp_locked;
    int         exp_lines;
    int         exp_active;
    logic [1:0] exp_level;
    logic       exp_field;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge iPCLK);
    #1;
  endtask

  task automatic vs_pulse(input bit with_hs);
    iVS = 1'b1;
    iDE = 1'b0;
    iCE = 1'b0;
    if (with_hs) iHS = 1'b1;
    tick();
    tick();
    iVS = 1'b0;
    iHS = 1'b0;
    tick();
  endtask

  task automatic lines(input int n, input int n_act, input int chg_line, input logic [1:0] chg_val);
    for (int j = 1; j <= n; j++) begin
      if (j == chg_line) iSCANLINES = chg_val;
      iHS = 1'b1;
      tick();
      iHS = 1'b0;
      if (chk_mode == 1)
        exp_ph = (chk_lvl == 2'd0) ? 2'd0 : exp_ph ^ chk_lvl;
      else if (chk_mode == 2)
        exp_ph = (chk_lvl == 2'd0) ? 2'd0 : ((exp_ph == chk_lvl) ? 2'd0 : exp_ph + 2'd1);
      if (chk_mode >= 0) sb.push_back((chk_mode == 0) ? 2'd0 : exp_ph);
      tick();
      if (j <= n_act) begin
        iDE = 1'b1; iCE = 1'b1;
        tick();
        tick();
      end else begin
        iDE = 1'b1; iCE = 1'b0;
        tick();
        iDE = 1'b0; iCE = 1'b1;
        tick();
      end
      iDE = 1'b0; iCE = 1'b0;
      tick();
    end
  endtask

  task automatic check_frame(input string tag, input logic lk, input int ln, input int ac,
                             input logic [1:0] lv, input logic fd);
    @(negedge iPCLK);
    check({tag, " oLOCKED"}, int'(oLOCKED), int'(lk));
    check({tag, " oLINES"},  int'(oLINES),  ln);
    check({tag, " oACTIVE"}, int'(oACTIVE), ac);
    check({tag, " oLEVEL"},  int'(oLEVEL),  int'(lv));
    check({tag, " oFIELD"},  int'(oFIELD),  int'(fd));
  endtask

  // Pops one expected level after each registered HS-only edge.
  logic hs_prev = 1'b0, vs_prev = 1'b0;
  always @(posedge iPCLK) begin
    bit   hs_ev;
    logic [1:0] e;
    hs_ev   = !iRST && hs_prev && !iHS && !(vs_prev && !iVS);
    hs_prev = iRST ? 1'b0 : iHS;
    vs_prev = iRST ? 1'b0 : iVS;
    if (hs_ev && sb.size() > 0) begin
      e = sb.pop_front();
      @(negedge iPCLK);
      check("oLEVEL per line", int'(oLEVEL), int'(e));
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //         scan  v2    falt  n    act  chg  cv    md lk    lines act  lvl   fld
    vecs[0] = '{2'd2, 1'b0, 1'b0, 262, 240, -1, 2'd0, 0, 1'b0, 0,   0,   2'd0, 1'b1};
    vecs[1] = '{2'd2, 1'b0, 1'b0, 262, 240, -1, 2'd0, 0, 1'b0, 262, 240, 2'd0, 1'b0};
    vecs[2] = '{2'd2, 1'b0, 1'b0, 262, 240, -1, 2'd0, 1, 1'b1, 262, 240, 2'd0, 1'b1};
    vecs[3] = '{2'd3, 1'b1, 1'b0, 262, 240, 100, 2'd1, 2, 1'b1, 262, 240, 2'd0, 1'b0};
    vecs[4] = '{2'd1, 1'b0, 1'b1, 262, 240, -1, 2'd0, 1, 1'b1, 262, 240, 2'd1, 1'b1};
    vecs[5] = '{2'd1, 1'b0, 1'b1, 263, 241, -1, 2'd0, 1, 1'b1, 262, 240, 2'd0, 1'b0};
    vecs[6] = '{2'd1, 1'b0, 1'b1, 262, 240, -1, 2'd0, 0, 1'b0, 263, 241, 2'd0, 1'b1};
    vecs[7] = '{2'd1, 1'b0, 1'b1, 262, 240, -1, 2'd0, 0, 1'b0, 262, 240, 2'd0, 1'b0};
    vecs[8] = '{2'd1, 1'b0, 1'b1, 262, 240, -1, 2'd0, 1, 1'b1, 262, 240, 2'd1, 1'b1};

    iRST = 1'b1; iSCANLINES = 2'd0; iV2 = 1'b0; iFIELD_ALT = 1'b0;
    iHS = 1'b0; iVS = 1'b0; iDE = 1'b0; iCE = 1'b0;
    tick(); tick(); tick();
    check_frame("reset", 1'b0, 0, 0, 2'd0, 1'b0);
    iRST = 1'b0;
    tick();

    for (int i = 0; i < 9; i++) begin
      iSCANLINES = vecs[i].scan;
      iV2        = vecs[i].v2;
      iFIELD_ALT = vecs[i].falt;
      vs_pulse(1'b0);
      check_frame($sformatf("frame%0d", i), vecs[i].exp_locked, vecs[i].exp_lines,
                  vecs[i].exp_active, vecs[i].exp_level, vecs[i].exp_field);
      chk_mode = vecs[i].mode;
      chk_lvl  = vecs[i].scan;
      exp_ph   = vecs[i].exp_level;
      lines(vecs[i].n_lines, vecs[i].n_act, vecs[i].chg_line, vecs[i].chg_val);
    end
    chk_mode = -1;

    // HS and VS falling together: frame start only, phase back to 0.
    @(negedge iPCLK);
    check("pre-joint oLEVEL", int'(oLEVEL), 1);
    vs_pulse(1'b1);
    check_frame("joint", 1'b1, 262, 240, 2'd0, 1'b0);
    lines(262, 240, -1, 2'd0);
    vs_pulse(1'b0);
    check_frame("after joint", 1'b1, 262, 240, 2'd1, 1'b1);

    // Reset mid-line with falling syncs in the reset cycle, and low syncs at release.
    iHS = 1'b1; iVS = 1'b1;
    tick(); tick();
    iHS = 1'b0; iVS = 1'b0; iRST = 1'b1;
    tick();
    check_frame("mid reset", 1'b0, 0, 0, 2'd0, 1'b0);
    iRST = 1'b0;
    tick(); tick();
    @(negedge iPCLK);
    check("release oFIELD", int'(oFIELD), 0);

    // Lock on 20-line frames, then an overflowing frame.
    vs_pulse(1'b0);
    lines(20, 0, -1, 2'd0);
    vs_pulse(1'b0);
    lines(20, 0, -1, 2'd0);
    vs_pulse(1'b0);
    @(negedge iPCLK);
    check("lock20 oLOCKED", int'(oLOCKED), 1);
    lines(1100, 0, -1, 2'd0);
    vs_pulse(1'b0);
    @(negedge iPCLK);
    check("ovf oLINES", int'(oLINES), 1023);
    check("ovf oLOCKED", int'(oLOCKED), 0);
    lines(20, 0, -1, 2'd0);
    vs_pulse(1'b0);
    @(negedge iPCLK);
    check("post-ovf search oLOCKED", int'(oLOCKED), 0);
    check("post-ovf oLINES", int'(oLINES), 20);
    lines(20, 0, -1, 2'd0);
    vs_pulse(1'b0);
    @(negedge iPCLK);
    check("post-ovf relock oLOCKED", int'(oLOCKED), 1);

    // Short frames never lock.
    iRST = 1'b1;
    tick(); tick();
    iRST = 1'b0;
    tick();
    for (int k = 0; k < 4; k++) begin
      vs_pulse(1'b0);
      @(negedge iPCLK);
      check($sformatf("short%0d oLOCKED", k), int'(oLOCKED), 0);
      if (k > 0) check($sformatf("short%0d oLINES", k), int'(oLINES), 8);
      lines(8, 8, -1, 2'd0);
    end

    check("scoreboard drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
